branch_hazard_unit: RTL
=======================

// Module: branch_hazard_unit
// PURPOSE
//  Producer side of the decode-stage branch/jr compare interface: drives fw_rd1/fw_rd2 mux selects,
//  pipeline stalls and the decode flush. Keeps a shadow E/M/W scoreboard of in-flight destination
//  registers, so forwarding/stall decisions need only D-stage decode fields. Sits beside the D stage.
// PARAMETERS
//  REG_AW  5   register address width
//  CNT_W   16  width of saturating stall-cycle counter
// PORTS
//  clk           in   1       clock, all state updates on posedge
//  rst_n         in   1       asynchronous active-low reset
//  instr_validD  in   1       D-stage holds a real instruction
//  rsD, rtD      in   REG_AW  D-stage source register numbers
//  use_rsD/use_rtD in 1       D instruction reads rs / rt
//  branchD       in   1       D instruction is beq/bne
//  jrD           in   1       D instruction is jr (reads rs only)
//  reg_writeD    in   1       D instruction writes a register
//  mem_to_regD   in   1       D instruction is a load
//  dest_regD     in   REG_AW  D instruction destination register
//  pc_srcD       in   1       branch/jr taken, from the branch resolution unit
//  fw_rd1        out  2       rs compare select: 00 regfile, 10 alu_outE, 01 alu_outM
//  fw_rd2        out  2       rt compare select, same encoding
//  stallF        out  1       hold PC
//  stallD        out  1       hold F/D register
//  flushE        out  1       insert bubble into D/E register
//  flushD        out  1       clear F/D register (taken-branch squash)
//  stall_cnt     out  CNT_W   saturating count of stall cycles since reset
// BEHAVIOUR
//  Scoreboard: slots E, M, W, each {wr, dest, load}. Reset: all slots 0, stall_cnt 0.
//  - Every posedge: W<=M, M<=E. E<=bubble if stall or ~instr_validD, else
//    {reg_writeD & dest_regD!=0, dest_regD, mem_to_regD}. Slots never hold while stalled.
//  - Match(slot,r) = slot.wr & slot.dest==r & r!=0. Register 0 never matches.
//  Branch operand (rs if (branchD|jrD)&use_rsD; rt if branchD&use_rtD), per operand:
//  - Match(E) & E.load          -> stall.
//  - Match(E) & ~E.load         -> select 10 (alu_outE this cycle), no stall.
//  - else Match(M) & M.load     -> stall (alu_outM is address, not data).
//  - else Match(M) & ~M.load    -> select 01.
//  - else 00. W-stage results come via write-first regfile; never forwarded.
//  - E priority over M when both match. fw_rd* = 00 while stall is high or D not branch/jr.
//  Load-use (non-branch): use_rsD/use_rtD operand Match(E) & E.load -> stall.
//  stall = OR of all stall causes, gated by instr_validD. stallF=stallD=flushE=stall.
//  flushD = pc_srcD & instr_validD & ~stall (compare with unresolved operands is ignored).
//  All outputs except stall_cnt combinational from slots + D inputs; latency 0 cycles.
//  Stall durations: load in E before branch -> 2 cycles; load in M -> 1; load-use ALU -> 1.
//  stall_cnt += 1 on each posedge with stall=1; saturates at all-ones, no wrap.
//  Async reset mid-stall: slots clear immediately, so stall/fw/flushE drop to 0 before next edge.
// STRUCTURE
//  Package mips_hazard_pkg: FW_NONE=2'b00, FW_EX=2'b10, FW_MEM=2'b01; scoreboard slot typedef
//  {wr, dest[REG_AW-1:0], load}, shared with the branch resolution unit and the forwarding unit.
//  One sub-module: hazard_operand_check (one operand vs E/M slots -> {sel[1:0], stall});
//  instantiated twice (rs, rt), load-use checks reuse its stall path.
// TESTING
//  1 add $9 in E; beq $9,$10 in D -> fw_rd1=10, fw_rd2=00, stall=0.
//  2 lw $9 in E; beq $9,$10 next -> stall=1 two cycles (slot E, then M), then fw_rd1=00,
//    stall=0; stall_cnt=2; E slot holds bubbles on both stalled edges.
//  3 add $10 in M, nop in E; bne $8,$10 in D -> fw_rd2=01; pc_srcD=1 -> flushD=1.
//  4 add $0 in E; beq $0,$0 -> fw 00/00, no stall. jr $31 with $31 written in E/M -> 10/01.
//  5 $9 written in both E and M; beq $9,$9 -> fw_rd1=fw_rd2=10; lw $9 in E + add $9 in D -> 1 stall.
//  6 rst_n low during step-2 stall -> stall,fw,flushE=0 immediately; stall_cnt=0;
//    force 2^CNT_W+3 stall cycles -> stall_cnt stays all-ones.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// Shared hazard-unit definitions: forwarding select encodings and the
// scoreboard slot layout used by the branch, resolution and forwarding units.
package mips_hazard_pkg;

    localparam int SLOT_AW = 5;

    localparam logic [1:0] FW_NONE = 2'b00;
    localparam logic [1:0] FW_EX   = 2'b10;
    localparam logic [1:0] FW_MEM  = 2'b01;

    typedef struct packed {
        logic               wr;
        logic [SLOT_AW-1:0] dest;
        logic               load;
    } sb_slot_t;

    localparam sb_slot_t SLOT_BUBBLE = '{wr: 1'b0, dest: {SLOT_AW{1'b0}}, load: 1'b0};

    // A slot supplies register r only if it writes it; $0 is hard-wired and never matches.
    function automatic logic slot_match(input sb_slot_t s, input logic [SLOT_AW-1:0] r);
        return s.wr & (s.dest == r) & (r != {SLOT_AW{1'b0}});
    endfunction

endpackage

// File: rtl/branch_hazard_unit_if.sv
// Decode-stage hazard bus: D-stage decode fields in, mux selects / stalls / flushes out.
interface branch_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              instr_validD;
    logic [REG_AW-1:0] rsD;
    logic [REG_AW-1:0] rtD;
    logic              use_rsD;
    logic              use_rtD;
    logic              branchD;
    logic              jrD;
    logic              reg_writeD;
    logic              mem_to_regD;
    logic [REG_AW-1:0] dest_regD;
    logic              pc_srcD;
    logic [1:0]        fw_rd1;
    logic [1:0]        fw_rd2;
    logic              stallF;
    logic              stallD;
    logic              flushE;
    logic              flushD;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output instr_validD, rsD, rtD, use_rsD, use_rtD, branchD, jrD,
               reg_writeD, mem_to_regD, dest_regD, pc_srcD,
        input  fw_rd1, fw_rd2, stallF, stallD, flushE, flushD, stall_cnt
    );

    modport slave (
        input  instr_validD, rsD, rtD, use_rsD, use_rtD, branchD, jrD,
               reg_writeD, mem_to_regD, dest_regD, pc_srcD,
        output fw_rd1, fw_rd2, stallF, stallD, flushE, flushD, stall_cnt
    );
endinterface

// File: rtl/branch_hazard_unit_operand_check.sv
// One source operand checked against the E and M scoreboard slots.
// E has priority over M; W is covered by the write-first register file.
module hazard_operand_check
    import mips_hazard_pkg::*;
(
    input  logic [SLOT_AW-1:0] reg_num,
    input  sb_slot_t           e_slot,
    input  sb_slot_t           m_slot,
    output logic [1:0]         sel,
    output logic               br_stall,
    output logic               lu_stall
);
    logic e_hit_s;
    logic m_hit_s;

    // Pick the compare-mux source, or stall when the producer is a load still in flight.
    always_comb begin
        e_hit_s  = slot_match(e_slot, reg_num);
        m_hit_s  = slot_match(m_slot, reg_num);
        sel      = FW_NONE;
        br_stall = 1'b0;
        lu_stall = e_hit_s & e_slot.load;
        if (e_hit_s) begin
            if (e_slot.load) begin
                br_stall = 1'b1;
            end else begin
                sel = FW_EX;
            end
        end else if (m_hit_s) begin
            // In M a load's ALU result is only the address, so the data is not ready yet.
            if (m_slot.load) begin
                br_stall = 1'b1;
            end else begin
                sel = FW_MEM;
            end
        end else begin
            sel = FW_NONE;
        end
    end
endmodule

// File: rtl/branch_hazard_unit.sv
// Decode-stage branch/jr hazard unit. Tracks in-flight destinations in a shadow
// E/M/W scoreboard so decisions only need D-stage decode fields.
module branch_hazard_unit
    import mips_hazard_pkg::*;
#(
    parameter int REG_AW = SLOT_AW,
    parameter int CNT_W  = 16
) (
    input logic                clk,
    input logic                rst_n,
    branch_hazard_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    sb_slot_t         e_slot_r, m_slot_r, w_slot_r;
    sb_slot_t         d_slot_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [1:0]       rs_sel_s, rt_sel_s;
    logic             rs_br_stall_s, rt_br_stall_s;
    logic             rs_lu_stall_s, rt_lu_stall_s;
    logic             rs_br_s, rt_br_s, stall_s;

    hazard_operand_check u_rs_check (
        .reg_num  (bus.rsD),
        .e_slot   (e_slot_r),
        .m_slot   (m_slot_r),
        .sel      (rs_sel_s),
        .br_stall (rs_br_stall_s),
        .lu_stall (rs_lu_stall_s)
    );

    hazard_operand_check u_rt_check (
        .reg_num  (bus.rtD),
        .e_slot   (e_slot_r),
        .m_slot   (m_slot_r),
        .sel      (rt_sel_s),
        .br_stall (rt_br_stall_s),
        .lu_stall (rt_lu_stall_s)
    );

    // Combine per-operand results into stall, compare selects and the taken-branch squash.
    always_comb begin
        rs_br_s = (bus.branchD | bus.jrD) & bus.use_rsD;
        rt_br_s = bus.branchD & bus.use_rtD;
        stall_s = bus.instr_validD &
                  ((rs_br_s & rs_br_stall_s) | (rt_br_s & rt_br_stall_s) |
                   (bus.use_rsD & rs_lu_stall_s) | (bus.use_rtD & rt_lu_stall_s));
        if (stall_s || !rs_br_s) begin
            bus.fw_rd1 = FW_NONE;
        end else begin
            bus.fw_rd1 = rs_sel_s;
        end
        if (stall_s || !rt_br_s) begin
            bus.fw_rd2 = FW_NONE;
        end else begin
            bus.fw_rd2 = rt_sel_s;
        end
        bus.stallF    = stall_s;
        bus.stallD    = stall_s;
        bus.flushE    = stall_s;
        // A taken decision made on unresolved operands is discarded while stalled.
        bus.flushD    = bus.pc_srcD & bus.instr_validD & ~stall_s;
        bus.stall_cnt = stall_cnt_r;
    end

    // Slot entering E: a bubble when stalled or D is empty, writes to $0 are dropped.
    always_comb begin
        if (stall_s || !bus.instr_validD) begin
            d_slot_s = SLOT_BUBBLE;
        end else begin
            d_slot_s.wr   = bus.reg_writeD & (bus.dest_regD != {REG_AW{1'b0}});
            d_slot_s.dest = bus.dest_regD;
            d_slot_s.load = bus.mem_to_regD;
        end
    end

    // Scoreboard always advances; a stall only changes what enters E.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_slot_r <= SLOT_BUBBLE;
            m_slot_r <= SLOT_BUBBLE;
            w_slot_r <= SLOT_BUBBLE;
        end else begin
            w_slot_r <= m_slot_r;
            m_slot_r <= e_slot_r;
            e_slot_r <= d_slot_s;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule
